mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that shares one 32x64k synchronous memory between the instruction-fetch port and the execute-stage data port of the core. It sits between ifetch/execute and the memory macro, grants at most one access per cycle, and returns read data one cycle after the grant. Fixed data-over-fetch priority is bounded by a starvation counter so fetch always makes progress.

## Interface
Parameters:
- ADDR, 16, memory address width (word address)
- WORD, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch read request; held until granted
- if_addr_i  in  ADDR  fetch address
- if_gnt_o  out  1  fetch granted this cycle (combinational)
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  WORD  fetch read data
- d_req_i  in  1  data request; held until granted
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR  data address
- d_wdata_i  in  WORD  write data
- d_gnt_o  out  1  data granted this cycle (combinational)
- d_rvalid_o  out  1  data read data valid
- d_rdata_o  out  WORD  data read data
- mem_a_o  out  ADDR  memory address
- mem_w_o  out  1  memory write enable
- mem_d_o  out  WORD  memory write data
- mem_q_i  in  WORD  memory read data, valid one cycle after address

## Operation
- Grant decision, per cycle, combinational from requests and state:
  - only one requester: it is granted.
  - both: data granted unless starve_cnt == STARVE_MAX, then fetch granted.
  - rst high: no grants.
- if_gnt_o and d_gnt_o never both 1.
- Memory drive: granted port's address (and for data, d_we_i/d_wdata_i) to mem_a_o/mem_w_o/mem_d_o. No grant: mem_a_o = 0, mem_w_o = 0, mem_d_o = 0. mem_w_o = 1 only when d_gnt_o & d_we_i.
- Read tag register rd_tag[1:0] = {fetch_read, data_read}: loaded each cycle with {if_gnt_o, d_gnt_o & ~d_we_i}.
- if_rvalid_o = rd_tag[1]; d_rvalid_o = rd_tag[0]. if_rdata_o/d_rdata_o = mem_q_i when respective rvalid, else 0.
- Data writes produce no rvalid.
- Starvation counter starve_cnt (4 bits):
  - if_req_i & ~if_gnt_o: increment, saturating at STARVE_MAX.
  - if_gnt_o or ~if_req_i: clear to 0.
- Requester dropping req before grant is legal; nothing is issued for it.

## Timing
- Reset values (after a rising edge with rst = 1): rd_tag = 0, starve_cnt = 0, so if_rvalid_o = d_rvalid_o = 0, rdata outputs 0; grants and mem outputs 0 while rst = 1.
- Grant latency 0 cycles (same cycle as request, if winning). Read latency 1 cycle: grant in cycle N -> rvalid and rdata in cycle N+1.
- Back-to-back grants allowed every cycle; reads in N and N+1 return in N+1 and N+2.
- Write in cycle N: memory updated at end of N; read of same address granted in N+1 returns new data in N+2.
- Contention: with both requesting continuously, pattern is STARVE_MAX data grants then 1 fetch grant, repeating.
- Reset mid-operation: read granted in cycle where rst = 1 cannot exist (grants gated); a read granted in cycle N with rst asserted in N+1 still returns rvalid in N+1, then cleared at the N+1 edge.
- Simultaneous grant of one port and rvalid of the other in the same cycle is normal; outputs are independent.

## Test plan
- Fetch only: if_req_i=1, addr 0x0010 for 3 cycles, mem preloaded mem[0x10..]=0xA0 -> if_gnt_o=1 each cycle, if_rvalid_o=1 in cycles 2-4, if_rdata_o=0xA0 each, d_rvalid_o=0 throughout.
- Write then read: data write 0x0020 <= 0xDEADBEEF in cycle 1, data read 0x0020 in cycle 2 -> mem_w_o=1 only in cycle 1, d_rvalid_o=1 in cycle 3 with 0xDEADBEEF, no rvalid in cycle 2.
- Contention with STARVE_MAX=4: both requesting 10 cycles -> grants D,D,D,D,F,D,D,D,D,F; starve_cnt reads 1,2,3,4,0 in pattern; never both grants.
- Mixed return routing: fetch read 0x0001 (mem=0x11) cycle 1, data read 0x0002 (mem=0x22) cycle 2 -> cycle 2 if_rdata_o=0x11 & d_rvalid_o=0; cycle 3 d_rdata_o=0x22 & if_rvalid_o=0.
- Reset mid-stream: reads granted continuously, rst=1 for cycle 5 -> no grants and mem_w_o=0 in cycle 5, rvalid in cycle 5 for cycle-4 grant, rvalid=0 and starve_cnt=0 in cycle 6, normal operation resumes cycle 6.
- Request withdrawal: if_req_i high 2 cycles under contention then low -> no fetch grant, no if_rvalid_o, starve_cnt returns to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one synchronous single-port memory between instruction fetch
// and the execute-stage data port; data wins ties unless fetch has starved.
module mem_arbiter #(
    parameter int ADDR       = 16,
    parameter int WORD       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_i,
    input  logic [ADDR-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [WORD-1:0] if_rdata_o,

    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [ADDR-1:0] d_addr_i,
    input  logic [WORD-1:0] d_wdata_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [WORD-1:0] d_rdata_o,

    output logic [ADDR-1:0] mem_a_o,
    output logic            mem_w_o,
    output logic [WORD-1:0] mem_d_o,
    input  logic [WORD-1:0] mem_q_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } gnt_e;

    gnt_e       gnt;
    logic       fetch_forced;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [1:0] rd_tag_q, rd_tag_d;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    assign fetch_forced = (starve_cnt_q == STARVE_LIM);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (if_req_i && (!d_req_i || fetch_forced)) begin
                gnt = GNT_FETCH;
            end else if (d_req_i) begin
                gnt = GNT_DATA;
            end
        end
    end

    assign if_gnt_o = (gnt == GNT_FETCH);
    assign d_gnt_o  = (gnt == GNT_DATA);

    // ------------------------------------------------------------------
    // Memory drive: idle cycles park the bus at zero
    // ------------------------------------------------------------------
    always_comb begin
        mem_a_o = '0;
        mem_w_o = 1'b0;
        mem_d_o = '0;
        case (gnt)
            GNT_FETCH: begin
                mem_a_o = if_addr_i;
            end
            GNT_DATA: begin
                mem_a_o = d_addr_i;
                mem_w_o = d_we_i;
                mem_d_o = d_wdata_i;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: read tags and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        rd_tag_d     = {if_gnt_o, d_gnt_o & ~d_we_i};
        starve_cnt_d = 4'd0;
        if (if_req_i && !if_gnt_o) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_tag_q     <= 2'b00;
            starve_cnt_q <= 4'd0;
        end else begin
            rd_tag_q     <= rd_tag_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read return routing, one cycle after the grant
    // ------------------------------------------------------------------
    assign if_rvalid_o = rd_tag_q[1];
    assign d_rvalid_o  = rd_tag_q[0];
    assign if_rdata_o  = if_rvalid_o ? mem_q_i : '0;
    assign d_rdata_o   = d_rvalid_o  ? mem_q_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural arbitration/memory model
// predicts grants and read returns; a negedge monitor compares against the DUT.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [15:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [15:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic [15:0] mem_a_o;
    logic        mem_w_o;
    logic [31:0] mem_d_o;
    logic [31:0] mem_q_i = '0;

    mem_arbiter #(.ADDR(16), .WORD(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_a_o(mem_a_o), .mem_w_o(mem_w_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Memory macro sitting outside the arbiter, and the golden contents the model believes in
    logic [31:0] macro_mem [int];
    logic [31:0] gold      [int];

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return {~a, a};
    endfunction

    function automatic logic [31:0] macro_rd(input logic [15:0] a);
        return macro_mem.exists(int'(a)) ? macro_mem[int'(a)] : init_val(a);
    endfunction

    function automatic logic [31:0] gold_rd(input logic [15:0] a);
        return gold.exists(int'(a)) ? gold[int'(a)] : init_val(a);
    endfunction

    task automatic preload(input logic [15:0] a, input logic [31:0] v);
        macro_mem[int'(a)] = v;
        gold[int'(a)]      = v;
    endtask

    always @(posedge clk) begin
        if (mem_w_o) macro_mem[int'(mem_a_o)] = mem_d_o;
        mem_q_i <= macro_rd(mem_a_o);
    end

    // Scoreboard entries
    typedef struct {
        int          cyc;
        bit          ig;
        bit          dg;
        logic [15:0] a;
        bit          w;
        logic [31:0] d;
        int          st;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rexp_t;

    gexp_t gnt_q[$];
    rexp_t if_rq[$];
    rexp_t d_rq[$];

    // Reference model state: cycles the fetch request has waited, saturating
    int fetch_wait = 0;
    bit m_if_gnt, m_d_gnt;

    task automatic drive_cycle(input bit r, input bit ir, input logic [15:0] ia,
                               input bit dr, input bit dwe, input logic [15:0] da,
                               input logic [31:0] dwd);
        gexp_t g;
        @(posedge clk);
        #1;
        cyc++;
        mon_en    = 1'b1;
        rst       = r;
        if_req_i  = ir;
        if_addr_i = ia;
        d_req_i   = dr;
        d_we_i    = dwe;
        d_addr_i  = da;
        d_wdata_i = dwd;

        m_if_gnt = !r && ir && (!dr || fetch_wait == STARVE_MAX);
        m_d_gnt  = !r && dr && !m_if_gnt;

        g.cyc = cyc;
        g.ig  = m_if_gnt;
        g.dg  = m_d_gnt;
        g.a   = m_if_gnt ? ia : (m_d_gnt ? da : 16'h0);
        g.w   = m_d_gnt && dwe;
        g.d   = m_d_gnt ? dwd : 32'h0;
        g.st  = fetch_wait;
        gnt_q.push_back(g);

        if (m_if_gnt) if_rq.push_back('{cyc + 1, gold_rd(ia)});
        if (m_d_gnt && !dwe) d_rq.push_back('{cyc + 1, gold_rd(da)});
        if (m_d_gnt && dwe) gold[int'(da)] = dwd;

        if (r || !ir || m_if_gnt) fetch_wait = 0;
        else if (fetch_wait < STARVE_MAX) fetch_wait++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    // Monitor: compares whatever the DUT presents in the current cycle
    always @(negedge clk) begin
        if (mon_en) begin
            gexp_t g;
            bit    exp_iv, exp_dv;
            check("gnt_exclusive", {63'd0, if_gnt_o & d_gnt_o}, 64'd0);
            if (gnt_q.size() == 0 || gnt_q[0].cyc != cyc) begin
                check("gnt_schedule", 64'(gnt_q.size()), 64'd1);
            end else begin
                g = gnt_q.pop_front();
                check("gnt", {62'd0, if_gnt_o, d_gnt_o}, {62'd0, g.ig, g.dg});
                check("mem_a_w", {47'd0, mem_a_o, mem_w_o}, {47'd0, g.a, g.w});
                if (!g.ig) check("mem_d", {32'd0, mem_d_o}, {32'd0, g.d});
                check("starve_cnt", {60'd0, dut.starve_cnt_q}, 64'(g.st));
            end

            exp_iv = (if_rq.size() != 0) && (if_rq[0].cyc == cyc);
            check("if_rvalid", {63'd0, if_rvalid_o}, {63'd0, exp_iv});
            if (exp_iv) check("if_rdata", {32'd0, if_rdata_o}, {32'd0, if_rq.pop_front().data});
            else        check("if_rdata_idle", {32'd0, if_rdata_o}, 64'd0);

            exp_dv = (d_rq.size() != 0) && (d_rq[0].cyc == cyc);
            check("d_rvalid", {63'd0, d_rvalid_o}, {63'd0, exp_dv});
            if (exp_dv) check("d_rdata", {32'd0, d_rdata_o}, {32'd0, d_rq.pop_front().data});
            else        check("d_rdata_idle", {32'd0, d_rdata_o}, 64'd0);
        end
    end

    initial begin
        bit          ip, dp, dwe;
        logic [15:0] ia, da;
        logic [31:0] dwd;

        preload(16'h0010, 32'h0000_00A0);
        preload(16'h0001, 32'h0000_0011);
        preload(16'h0002, 32'h0000_0022);

        // Reset
        for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b1, 16'h5, 1'b1, 1'b1, 16'h6, 32'h1);
        idle(1);

        // Fetch only, same address three times
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
        idle(1);

        // Write then read back
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 32'hDEAD_BEEF);
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
        idle(1);

        // Contention: fetch held, data issuing fresh reads every cycle
        for (int i = 0; i < 10; i++)
            drive_cycle(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 16'(32 + i), 32'h0);
        idle(1);

        // Mixed return routing
        drive_cycle(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 32'h0);
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0002, 32'h0);
        idle(1);

        // Reset in the middle of back-to-back reads
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 32'h0);
        drive_cycle(1'b1, 1'b1, 16'h4, 1'b1, 1'b1, 16'h7, 32'h1234_5678);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b1, 16'(5 + i), 1'b0, 1'b0, 16'h0, 32'h0);
        idle(1);

        // Fetch withdraws under contention before being served
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 16'(40 + i), 32'h0);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'(42 + i), 32'h0);
        idle(1);

        // Randomized traffic: requests held until granted, occasional withdrawal and reset
        ip = 0; dp = 0; ia = '0; da = '0; dwe = 0; dwd = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!ip) begin
                ip = ($urandom_range(0, 2) != 0);
                ia = 16'($urandom_range(0, 31));
            end else if ($urandom_range(0, 15) == 0) begin
                ip = 0;
            end
            if (!dp) begin
                dp  = ($urandom_range(0, 3) != 0);
                da  = 16'($urandom_range(0, 31));
                dwe = $urandom_range(0, 1) == 1;
                dwd = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                dp = 0;
            end
            drive_cycle($urandom_range(0, 63) == 0, ip, ia, dp, dwe, da, dwd);
            if (m_if_gnt) ip = 0;
            if (m_d_gnt)  dp = 0;
        end

        idle(2);
        @(negedge clk);
        #1;
        check("drain_if", 64'(if_rq.size()), 64'd0);
        check("drain_d", 64'(d_rq.size()), 64'd0);
        check("drain_gnt", 64'(gnt_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
